// File: rtl/duty_pkg.sv
// Shared types and constants for the duty slew controller and its PWM consumer.
package duty_pkg;

  localparam int unsigned DUTY_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV enabled clocks; freezes while run is low.
module tick_gen #(
  parameter int unsigned TICK_DIV = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = run && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/duty_slew_ctrl.sv
// Owns the live PWM duty: slews it toward a software-written target one STEP per tick,
// or jumps on request, and reports busy/done status.
module duty_slew_ctrl
  import duty_pkg::*;
#(
  parameter int unsigned WIDTH    = DUTY_WIDTH,
  parameter int unsigned TICK_DIV = 256,
  parameter int unsigned STEP     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] target_in,
  input  logic             jump,
  input  logic             hold,
  output logic [WIDTH-1:0] duty_out,
  output logic             pwm_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] target_q
);

  localparam logic [WIDTH:0] STEP_X = (WIDTH + 1)'(STEP);

  state_t           state, state_next;
  logic [WIDTH-1:0] duty_next, target_next, stepped;
  logic [WIDTH:0]   duty_x, target_x, up_sum, dn_floor;
  logic             done_next, tick, clear, run;

  assign run  = (state == RAMP) && !hold;
  assign busy = (state == RAMP);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .clear(clear),
    .tick (tick)
  );

  // Saturating step in WIDTH+1 bits so neither overshoot nor borrow can wrap.
  always_comb begin
    duty_x   = {1'b0, duty_out};
    target_x = {1'b0, target_q};
    up_sum   = duty_x + STEP_X;
    dn_floor = target_x + STEP_X;
    stepped  = duty_out;
    if (target_x > duty_x) begin
      stepped = (up_sum >= target_x) ? target_q : up_sum[WIDTH-1:0];
    end else if (duty_x <= dn_floor) begin
      stepped = target_q;
    end else begin
      stepped = duty_out - STEP_X[WIDTH-1:0];
    end
  end

  // A write takes priority over a coincident tick; the tick still wraps the counter.
  always_comb begin
    state_next  = state;
    duty_next   = duty_out;
    target_next = target_q;
    done_next   = 1'b0;
    clear       = 1'b0;
    if (wr_en) begin
      target_next = target_in;
      if (jump) begin
        duty_next  = target_in;
        state_next = IDLE;
        done_next  = 1'b1;
        clear      = 1'b1;
      end else begin
        clear = (state == IDLE);
        if (target_in == duty_out) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = RAMP;
        end
      end
    end else if (tick) begin
      duty_next = stepped;
      if (stepped == target_q) begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_out <= '0;
      target_q <= '0;
      pwm_en   <= 1'b0;
      done     <= 1'b0;
    end else begin
      duty_out <= duty_next;
      target_q <= target_next;
      pwm_en   <= (duty_next != '0);
      done     <= done_next;
    end
  end

endmodule

// File: tb/tb_duty_slew_ctrl.sv
// Scoreboard bench: stimulus predicts each visible duty/done event; a monitor pops and compares.
module tb_duty_slew_ctrl;

  localparam int W  = 8;
  localparam int TD = 4;
  localparam int ST = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en;
  logic         jump;
  logic         hold;
  logic [W-1:0] target_in;
  logic [W-1:0] duty_out;
  logic [W-1:0] target_q;
  logic         pwm_en;
  logic         busy;
  logic         done;

  duty_slew_ctrl #(
    .WIDTH   (W),
    .TICK_DIV(TD),
    .STEP    (ST)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .target_in(target_in),
    .jump     (jump),
    .hold     (hold),
    .duty_out (duty_out),
    .pwm_en   (pwm_en),
    .busy     (busy),
    .done     (done),
    .target_q (target_q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           at;
    logic [W-1:0] duty;
    logic         dn;
    logic         bz;
    logic [W-1:0] tgt;
  } ev_t;

  ev_t          q[$];
  ev_t          ev;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] prev_duty = '0;
  int           m_duty = 0;

  // Monitor: any duty change or done pulse is a DUT output event.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_duty = '0;
    end else begin
      while (q.size() != 0 && q[0].at < cyc) begin
        ev = q.pop_front();
        checks++; errors++;
        $display("FAIL missed_event: expected at edge %0d duty=%0d done=%0b, nothing seen (now edge %0d)",
                 ev.at, ev.duty, ev.dn, cyc);
      end
      if (duty_out !== prev_duty || done !== 1'b0) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: edge=%0d duty=%0d done=%0b busy=%0b, required no change",
                   cyc, duty_out, done, busy);
        end else begin
          ev = q.pop_front();
          if (cyc !== ev.at || duty_out !== ev.duty || done !== ev.dn || busy !== ev.bz ||
              pwm_en !== (ev.duty != 0) || target_q !== ev.tgt) begin
            errors++;
            $display("FAIL event: got edge=%0d duty=%0d done=%0b busy=%0b pwm_en=%0b target_q=%0d; required edge=%0d duty=%0d done=%0b busy=%0b pwm_en=%0b target_q=%0d",
                     cyc, duty_out, done, busy, pwm_en, target_q,
                     ev.at, ev.duty, ev.dn, ev.bz, (ev.duty != 0), ev.tgt);
          end
        end
      end
      prev_duty = duty_out;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic push(input int at, input int d, input bit dn, input bit bz, input int t);
    ev_t e;
    e.at = at; e.duty = W'(d); e.dn = dn; e.bz = bz; e.tgt = W'(t);
    q.push_back(e);
  endtask

  // Reference: a step lands after every TD non-held clocks following the write edge.
  task automatic gen_ramp(input int k, input int d, input int t, input int hs, input int hl);
    int cnt = 0;
    int cur = d;
    int e = k;
    for (int i = 0; i < 2000; i++) begin
      e++;
      if (e >= hs && e < hs + hl) continue;
      cnt++;
      if (cnt % TD == 0) begin
        if (t > cur) cur = (cur + ST > t) ? t : cur + ST;
        else         cur = (cur - ST < t) ? t : cur - ST;
        push(e, cur, cur == t, cur != t, t);
        if (cur == t) break;
      end
    end
  endtask

  // One write from IDLE; hold is driven high on edges [k+hoff, k+hoff+hl).
  task automatic txn(input int t, input bit j, input int hoff, input int hl);
    int k, hs, n;
    k  = cyc + 1;
    hs = k + hoff;
    if (j || t == m_duty) push(k, t, 1'b1, 1'b0, t);
    else gen_ramp(k, m_duty, t, hs, hl);
    n = 0;
    while (n < 400) begin
      wr_en     = (cyc + 1 == k);
      target_in = W'(t);
      jump      = j;
      hold      = (cyc + 1 >= hs && cyc + 1 < hs + hl);
      @(negedge clk);
      n++;
      if (cyc == k) check("busy_after_write", int'(busy), int'(!j && t != m_duty));
      if (cyc >= hs + hl && cyc > k && q.size() == 0) break;
    end
    wr_en = 1'b0; hold = 1'b0; jump = 1'b0;
    m_duty = t;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout: %0d events pending, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic drive_write(input int at, input int t, input bit j);
    while (cyc + 1 < at) @(negedge clk);
    wr_en = 1'b1; target_in = W'(t); jump = j;
    @(negedge clk);
    wr_en = 1'b0; jump = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d events pending, required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, t, hl, hoff;
    bit j;
    rst_n = 1'b0; wr_en = 1'b0; jump = 1'b0; hold = 1'b0; target_in = '0;
    @(negedge clk);
    check("reset_duty", int'(duty_out), 0);
    check("reset_target", int'(target_q), 0);
    check("reset_busy_done_pwm", int'({busy, done, pwm_en}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    txn(64, 1'b0, 0, 0);
    txn(70, 1'b0, 0, 0);
    txn(3, 1'b0, 0, 0);
    txn(0, 1'b0, 0, 0);
    check("pwm_en_at_zero", int'(pwm_en), 0);
    txn(10, 1'b1, 0, 0);
    txn(200, 1'b1, 0, 3);
    txn(200, 1'b0, 0, 0);
    txn(0, 1'b1, 0, 0);
    txn(128, 1'b0, 6, 10);

    for (int i = 0; i < 25; i++) begin
      t = $urandom_range(0, 255);
      if ($urandom_range(0, 5) == 0) t = m_duty;
      j    = ($urandom_range(0, 3) == 0);
      hl   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0;
      hoff = $urandom_range(0, 20);
      txn(t, j, hoff, hl);
    end

    // Mid-ramp retarget keeps tick phase: reversal lands on the original grid.
    txn(0, 1'b1, 0, 0);
    k = cyc + 1;
    push(k + 4, 16, 1'b0, 1'b1, 128);
    push(k + 8, 32, 1'b0, 1'b1, 128);
    push(k + 12, 16, 1'b1, 1'b0, 16);
    drive_write(k, 128, 1'b0);
    drive_write(k + 9, 16, 1'b0);
    drain(100);
    m_duty = 16;

    // Write coinciding with a tick edge: that step is skipped.
    k = cyc + 1;
    push(k + 4, 32, 1'b0, 1'b1, 96);
    for (int i = 0; i < 6; i++) push(k + 12 + 4 * i, 48 + 16 * i, i == 5, i != 5, 128);
    drive_write(k, 96, 1'b0);
    drive_write(k + 8, 128, 1'b0);
    drain(100);
    m_duty = 128;

    // Asynchronous reset between edges in the middle of a ramp.
    k = cyc + 1;
    push(k + 4, 144, 1'b0, 1'b1, 240);
    push(k + 8, 160, 1'b0, 1'b1, 240);
    drive_write(k, 240, 1'b0);
    while (cyc < k + 9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_duty", int'(duty_out), 0);
    check("async_rst_target", int'(target_q), 0);
    check("async_rst_pwm_en", int'(pwm_en), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    q.delete();
    m_duty = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_duty", int'(duty_out), 0);
    check("post_rst_busy", int'(busy), 0);
    txn(48, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/duty_slew_ctrl.md
Name: duty_slew_ctrl

Overview:
- Upstream feeder for pwm_generator: owns the duty_cycle value that drives pwm_generator's duty_cycle and en inputs.
- Accepts target writes from the processor's memory-mapped I/O path.
- Slews the live duty toward the target by STEP every TICK_DIV clocks, or jumps immediately on request, so motors/LEDs never see abrupt duty changes.
- Reports busy/done status back to software.

Parameters:
- WIDTH, 8, duty/target bit width; matches pwm_generator duty_cycle.
- TICK_DIV, 256, clocks per slew step; legal range >= 2.
- STEP, 1, duty increment/decrement per step; legal range 1..2^WIDTH-1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  one-cycle write strobe for target_in/jump
- target_in  input  WIDTH  requested duty target
- jump  input  1  sampled with wr_en; 1 = load target immediately, 0 = slew
- hold  input  1  while high, freezes slewing (tick counter and duty hold)
- duty_out  output  WIDTH  live duty; connects to pwm_generator duty_cycle
- pwm_en  output  1  registered, high when duty_out != 0; connects to pwm_generator en
- busy  output  1  high while state == RAMP
- done  output  1  one-cycle pulse when duty_out reaches target
- target_q  output  WIDTH  current registered target (status readback)

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n). All state updates on posedge clk.
- rst_n low forces, immediately: duty_out=0, target_q=0, pwm_en=0, busy=0, done=0, state=IDLE, tick counter=0.
- Releasing reset mid-ramp loses the ramp; the block restarts from 0.
- States:
  - IDLE: no write pending.
  - RAMP: duty_out != target_q, slewing.
- Write with jump=0 at edge k:
  - target_q <= target_in at edge k.
  - If the new target != duty_out: state <= RAMP, busy=1 from cycle k+1.
  - If the new target == duty_out: stay IDLE; done pulses at cycle k+1.
  - A write accepted in IDLE clears the tick counter. A write during RAMP leaves the counter running and only retargets; direction is recomputed from the new target_q.
- Write with jump=1 at edge k:
  - duty_out <= target_in and target_q <= target_in at edge k.
  - state <= IDLE, busy=0, counter cleared, done pulses at cycle k+1 (also when already equal).
  - jump overrides hold.
- Tick rules:
  - In RAMP with hold=0, the counter increments each clock.
  - When the counter == TICK_DIV-1 it wraps to 0 and a step occurs on that same edge.
  - The first step therefore lands TICK_DIV clocks after the write edge.
- Step arithmetic, computed in WIDTH+1 bits with no wrap-around:
  - Up: duty_out <= min(duty_out+STEP, target_q).
  - Down: duty_out <= max(duty_out-STEP, target_q), borrow-safe, so duty 3 with STEP=16 toward target 0 yields 0.
- Arrival:
  - The step edge that makes duty_out == target_q also sets state <= IDLE, busy <= 0, done <= 1 for exactly one cycle.
  - Counter returns to 0.
- hold=1 in RAMP: counter and duty_out frozen, busy stays 1; the ramp resumes from the frozen counter value when hold drops.
- Simultaneous wr_en and tick edge: the write wins. The step for that edge is skipped; the counter still wraps to 0.
- pwm_en: registered from the next duty value, so it changes on the same edge as duty_out.
- done: never asserted together with busy.

Decomposition:
- Shared package duty_pkg:
  - state enum {IDLE, RAMP}.
  - DUTY_WIDTH default constant = 8, shared with pwm_generator.
- Sub-module tick_gen (parameter TICK_DIV):
  - Inputs clk, rst_n, run, clear.
  - Output tick, one cycle at counter == TICK_DIV-1.
  - Reused by other timed peripherals.
- Remaining FSM plus saturating step logic sits in duty_slew_ctrl.

Test Plan (TICK_DIV=4, STEP=16 unless noted):
- Up ramp: reset, then write target 64, jump=0.
  - busy=1 next cycle.
  - duty 16/32/48/64 at 4/8/12/16 clocks after the write edge.
  - done pulse coincides with busy falling; pwm_en rises with duty 16.
- Overshoot clamp: from duty 64, write 70.
  - duty reaches 70 after one tick, not 80; done=1 for one cycle.
  - Then write 3 from 70 (down ramp): duty 54, 38, 22, 6, 3; then write 0 gives 0 with pwm_en low after the step.
- Jump and equal-target writes:
  - From duty 10, write 200 with jump=1: duty_out=200 next cycle, busy never 1, done pulses once.
  - Write 200 again with jump=0: done pulses, busy stays 0.
- Retarget mid-ramp: ramp 0->128; after duty=32, write 16.
  - Direction reverses and duty reaches 16 on the next tick.
  - Tick spacing is unchanged (counter not cleared).
  - Separately, writing on the exact tick edge skips that step.
- hold: hold=1 for 10 clocks mid-ramp.
  - duty_out and busy frozen.
  - After release, the next step lands TICK_DIV minus the frozen count later.
- Async reset: assert rst_n=0 mid-ramp between clock edges.
  - All outputs read 0 before the next posedge.
  - After release with no writes: IDLE, duty 0 held for 20 clocks.
